// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Shift-add multiply or restoring divide, one bit per cycle, with a registered result and a Done_E pulse.
module execute_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start_E,
  input  logic [2:0]      MD_Op_E,
  input  logic [XLEN-1:0] Operand_A_E,
  input  logic [XLEN-1:0] Operand_B_E,
  input  logic            Flush_E,
  output logic            Busy_E,
  output logic            Done_E,
  output logic [XLEN-1:0] MD_Out_E
);

  localparam int unsigned IW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              done_q, done_d;

  logic              start_ok, fin;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    out_d    = out_q;
    done_d   = 1'b0;
    fin      = 1'b0;

    start_ok = (state_q == S_IDLE) && Start_E && !Flush_E;
    a_sgn    = (MD_Op_E == 3'b001) || (MD_Op_E == 3'b010) || (MD_Op_E == 3'b100) || (MD_Op_E == 3'b110);
    b_sgn    = (MD_Op_E == 3'b001) || (MD_Op_E == 3'b100) || (MD_Op_E == 3'b110);
    a_neg    = a_sgn & Operand_A_E[XLEN-1];
    b_neg    = b_sgn & Operand_B_E[XLEN-1];
    a_mag    = a_neg ? -Operand_A_E : Operand_A_E;
    b_mag    = b_neg ? -Operand_B_E : Operand_B_E;
    div_zero = (Operand_B_E == '0);
    div_ovf  = !MD_Op_E[0] && (Operand_A_E == {1'b1, {(XLEN-1){1'b0}}}) && (Operand_B_E == '1);
    special  = MD_Op_E[2] && (div_zero || div_ovf);

    // acc holds {partial product hi, multiplier} or {partial remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d   = MD_Op_E;
          iter_d = '0;
          if (special) begin
            // Preload acc so the common finish path yields the architected special results
            acc_d   = div_zero ? {Operand_A_E, {XLEN{1'b1}}} : {{XLEN{1'b0}}, Operand_A_E};
            opb_d   = Operand_B_E;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_FINISH;
            fin     = 1'b1;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opb_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[XLEN-1:1]};
          else          acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(XLEN-1)) begin
          iter_d  = '0;
          state_d = S_FINISH;
          fin     = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Sign correction is applied on the edge entering FINISH so MD_Out_E is valid with Done_E
    prod = negq_d ? -acc_d : acc_d;
    quo  = acc_d[XLEN-1:0];
    rem  = acc_d[2*XLEN-1:XLEN];
    if (op_d[2]) begin
      if (op_d[1]) result = negr_d ? -rem : rem;
      else         result = negq_d ? -quo : quo;
    end else begin
      result = (op_d[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    if (fin) begin
      out_d  = result;
      done_d = 1'b1;
    end

    if (Flush_E) begin
      state_d = S_IDLE;
      iter_d  = '0;
      out_d   = out_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign Busy_E   = (state_q != S_IDLE);
  assign Done_E   = done_q;
  assign MD_Out_E = out_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: XLEN=32 vectors, flush/reset behaviour, and an XLEN=8 sweep against a behavioural model.
module tb_execute_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start32, start8, flush32, flush8;
  logic [2:0]  MD_Op;
  logic [31:0] OpA, OpB;
  logic        busy32, done32, busy8, done8;
  logic [31:0] out32;
  logic [7:0]  out8;
  logic        sel8;
  logic        busy_s, done_s;
  logic [31:0] out_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  execute_muldiv #(.XLEN(32)) dut32 (
    .CLK(CLK), .RST(RST), .Start_E(start32), .MD_Op_E(MD_Op),
    .Operand_A_E(OpA), .Operand_B_E(OpB), .Flush_E(flush32),
    .Busy_E(busy32), .Done_E(done32), .MD_Out_E(out32)
  );

  execute_muldiv #(.XLEN(8)) dut8 (
    .CLK(CLK), .RST(RST), .Start_E(start8), .MD_Op_E(MD_Op),
    .Operand_A_E(OpA[7:0]), .Operand_B_E(OpB[7:0]), .Flush_E(flush8),
    .Busy_E(busy8), .Done_E(done8), .MD_Out_E(out8)
  );

  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign out_s  = sel8 ? {24'h0, out8} : out32;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 8'h80) && (b == 8'hFF);
    case (op)
      3'd0: p = (ua * ub);
      3'd1: p = (sa * sb) >>> 8;
      3'd2: p = (sa * ub) >>> 8;
      3'd3: p = (ua * ub) >> 8;
      3'd4: p = (b == 0) ? -1 : (ovf ? sa : sa / sb);
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : (ovf ? 0 : sa % sb);
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[7:0];
  endfunction

  // Called at #1 after an edge with the DUT idle; that cycle is cycle 0.
  task automatic run_op(input bit s8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cyc, input string tag);
    int c;
    int busy_n;
    sel8 = s8;
    MD_Op = op; OpA = a; OpB = b;
    if (s8) start8 = 1'b1; else start32 = 1'b1;
    chk({tag, "_busy_c0"}, 32'(busy_s), 32'd0);
    @(posedge CLK); #1;
    start8 = 1'b0; start32 = 1'b0;
    OpA = ~a; OpB = a ^ b; MD_Op = ~op;
    c = 1; busy_n = 0;
    while (!done_s && c < 100) begin
      if (busy_s) busy_n++;
      @(posedge CLK); #1;
      c++;
    end
    if (busy_s) busy_n++;
    chk({tag, "_cycle"}, 32'(c), 32'(exp_cyc));
    chk({tag, "_done"}, 32'(done_s), 32'd1);
    chk({tag, "_out"}, out_s, exp);
    chk({tag, "_busycnt"}, 32'(busy_n), 32'(exp_cyc));
    @(posedge CLK); #1;
    chk({tag, "_done_drop"}, 32'(done_s), 32'd0);
    chk({tag, "_idle"}, 32'(busy_s), 32'd0);
  endtask

  initial begin
    int c;
    int dseen;
    logic [7:0] a8, b8;
    int ecyc;
    RST = 1'b1; start32 = 1'b0; start8 = 1'b0; flush32 = 1'b0; flush8 = 1'b0;
    MD_Op = 3'd0; OpA = '0; OpB = '0; sel8 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy32", 32'(busy32), 32'd0);
    chk("rst_done32", 32'(done32), 32'd0);
    chk("rst_out32", out32, 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_out8", 32'(out8), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op(0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run_op(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    run_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run_op(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
    run_op(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div");
    run_op(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem");
    run_op(0, 3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, "divu");
    run_op(0, 3'd7, 32'hFFFFFFF9, 32'd2,        32'd1,        33, "remu");
    run_op(0, 3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1,  "divu_z");
    run_op(0, 3'd6, 32'h1234,     32'd0,        32'h1234,     1,  "rem_z");
    run_op(0, 3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  "rem_zneg");
    run_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    run_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");
    run_op(0, 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "remu_noovf");
    run_op(0, 3'd0, 32'd3,        32'd5,        32'd15,       33, "mul_prev");

    // Flush at cycle 10, ignored start at cycle 5, restart at cycle 11
    sel8 = 1'b0;
    MD_Op = 3'd0; OpA = 32'h1111; OpB = 32'd2; start32 = 1'b1;
    @(posedge CLK); #1;
    start32 = 1'b0;
    c = 1; dseen = 0;
    while (c < 10) begin
      if (done32) dseen++;
      if (c == 5) begin start32 = 1'b1; MD_Op = 3'd5; OpB = 32'd0; end
      @(posedge CLK); #1;
      start32 = 1'b0;
      c++;
    end
    chk("flush_busy_c10", 32'(busy32), 32'd1);
    flush32 = 1'b1;
    @(posedge CLK); #1;
    flush32 = 1'b0;
    if (done32) dseen++;
    chk("flush_nodone", 32'(dseen), 32'd0);
    chk("flush_busy_c11", 32'(busy32), 32'd0);
    chk("flush_out_kept", out32, 32'd15);
    run_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "after_flush");

    // Start and flush together in IDLE: start refused
    MD_Op = 3'd5; OpA = 32'h55; OpB = 32'd0; start32 = 1'b1; flush32 = 1'b1;
    @(posedge CLK); #1;
    start32 = 1'b0; flush32 = 1'b0;
    chk("startflush_busy", 32'(busy32), 32'd0);
    @(posedge CLK); #1;
    chk("startflush_done", 32'(done32), 32'd0);
    chk("startflush_out", out32, 32'hFFFFFFEB);

    // Reset mid-operation
    MD_Op = 3'd0; OpA = 32'd9; OpB = 32'd9; start32 = 1'b1;
    @(posedge CLK); #1;
    start32 = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_busy", 32'(busy32), 32'd0);
    chk("midrst_done", 32'(done32), 32'd0);
    chk("midrst_out", out32, 32'd0);
    dseen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done32) dseen++;
    end
    chk("midrst_nodone", 32'(dseen), 32'd0);

    // XLEN=8 sweep: boundary operands first, then pseudo-random pairs
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 16; k++) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (k == 0) b8 = 8'h00;
        if (k == 1) begin a8 = 8'h80; b8 = 8'hFF; end
        if (k == 2) begin a8 = 8'h80; b8 = 8'h01; end
        if (k == 3) begin a8 = 8'hFF; b8 = 8'h80; end
        ecyc = 9;
        if (op >= 4 && (b8 == 8'h00 || (op[0] == 1'b0 && a8 == 8'h80 && b8 == 8'hFF))) ecyc = 1;
        run_op(1, 3'(op), {24'h0, a8}, {24'h0, b8}, {24'h0, ref8(3'(op), a8, b8)}, ecyc,
               $sformatf("x8_op%0d_%02h_%02h", op, a8, b8));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
